dark_level_alarm: RTL and testbench
===================================

# dark_level_alarm

Parametrised brightness-window alarm. It watches a per-frame dark-pixel count from the capture path and debounces out-of-window readings before it drives the buzzer. It also mirrors the count, plus a running peak, to the 7-segment display path. It adds configurable thresholds, hysteresis, debounce depth, a pulsed-beep mode and operator acknowledge.

## Interface
- DATA_W, 16, width of the dark-count sample
- DISP_W, 32, width of display output; sample is zero-extended (DISP_W >= DATA_W)
- LOW_TH, 16'h0600, sample < LOW_TH is out-of-window
- HIGH_TH, 16'h4000, sample > HIGH_TH is out-of-window
- HYST, 16'h0040, recovery band; legal only if LOW_TH+HYST <= HIGH_TH-HYST
- DEB_CNT, 3, consecutive qualifying samples needed to enter or leave alarm (>= 1)
- BEEP_HALF, 2500000, iCLK cycles per half-period in pulsed mode (>= 1)
- iCLK  in  1  clock
- iRST  in  1  asynchronous, active-low reset
- iValid  in  1  one-cycle strobe; iValue is a new sample
- iValue  in  DATA_W  dark-pixel count
- iMode  in  2  0 = silent, 1 = continuous tone, 2 = pulsed beep, 3 = treated as 1
- iAck  in  1  one-cycle strobe: mute current alarm, clear peak
- oSound_on  out  1  buzzer enable
- oAlarm_state  out  2  FSM state: 0 NORMAL, 1 PENDING, 2 ALARM, 3 RECOVER
- oDisplayDIG  out  DISP_W  last valid sample, zero-extended
- oPeak  out  DATA_W  maximum valid sample since reset/last iAck

## Operation
- Sample classes, all unsigned:
  - OUT = iValue < LOW_TH or iValue > HIGH_TH
  - OK = LOW_TH+HYST <= iValue <= HIGH_TH-HYST
  - BAND = neither OUT nor OK
- Debounce counter cnt is sized to hold DEB_CNT. The FSM advances only on cycles with iValid=1 and holds otherwise.
- NORMAL:
  - OUT: if DEB_CNT==1, go to ALARM; else go to PENDING with cnt=1.
  - BAND or OK: stay.
- PENDING:
  - OUT: cnt+1. When cnt+1 == DEB_CNT, go to ALARM and clear cnt.
  - BAND or OK: go to NORMAL and clear cnt.
- ALARM:
  - OK: if DEB_CNT==1, go to NORMAL; else go to RECOVER with cnt=1.
  - OUT or BAND: stay and clear cnt.
- RECOVER:
  - OK: cnt+1. When cnt+1 == DEB_CNT, go to NORMAL.
  - OUT or BAND: go back to ALARM and clear cnt.
- Mute flag:
  - iAck in ALARM or RECOVER sets mute.
  - mute clears on every transition into ALARM from PENDING/NORMAL, and on entering NORMAL.
  - The RECOVER-to-ALARM transition does not clear mute.
- Sound, with armed = state in {ALARM, RECOVER} and not mute:
  - Mode 0: oSound_on = 0.
  - Mode 1/3: oSound_on = armed.
  - Mode 2: oSound_on = armed and beep phase high.
  - Beep counter: phase is high for BEEP_HALF cycles, then low for BEEP_HALF, repeating. The counter resets to phase-high/count 0 on each entry into ALARM from PENDING/NORMAL and free-runs while armed.
- Display: on iValid, oDisplayDIG <= zero-extended iValue, in every state and mode.
- Peak:
  - on iValid, oPeak <= max(oPeak, iValue).
  - iAck alone clears it to 0.
  - iAck with iValid in the same cycle loads iValue.

## Timing
- Reset: state NORMAL, cnt 0, mute 0, beep counter 0, all outputs 0.
- Reset is asynchronous. Assertion mid-alarm drops oSound_on and all state in the same instant, with no clock needed.
- All outputs are registered.
- oAlarm_state and oSound_on change on the same iCLK edge that samples the qualifying iValid. Latency is one edge from the DEB_CNT-th qualifying strobe.
- iAck takes effect at the edge that samples it: oSound_on is low from that edge.
- iAck and an OUT sample that moves PENDING to ALARM in the same cycle: the entry wins, so mute=0 and sound comes on.
- iMode is sampled every cycle. A change alters oSound_on at the next edge without affecting the FSM.
- Non-strobe cycles: FSM and cnt hold; only the beep counter advances.

## Test plan
- Defaults, DEB_CNT=3, iMode=1. Valid samples 0x0500, 0x0500, 0x0500 -> state 1, 1, 2; oSound_on rises on the 3rd strobe edge. oDisplayDIG = 0x00000500.
- Samples 0x0500, 0x0500, 0x1000 -> state returns to 0, oSound_on stays 0. A following 0x0500 restarts the count at 1.
- From ALARM: samples 0x0620 (BAND) -> stays 2. Then 0x1000 ×3 -> state 3, 3, 0; oSound_on falls on the 3rd. A 0x4100 mid-recovery -> state 2.
- iMode=2, BEEP_HALF=4. Enter ALARM -> oSound_on is 1 for 4 cycles, 0 for 4, repeating. iAck -> 0 on the next edge and remains 0. A re-entry from NORMAL -> beeps again.
- Peak: samples 0x0200, 0x3000, 0x1000 -> oPeak 0x3000. iAck with iValid 0x0100 in the same cycle -> oPeak 0x0100.
- Assert iRST mid-beep with iCLK stopped -> all outputs 0 immediately, state 0 after release.

Source files
------------

// File: rtl/dark_level_alarm.sv
// dark_level_alarm: debounced brightness-window alarm for the capture path.
// Classifies each valid dark-pixel count as OUT / BAND / OK, runs a
// four-state debounce FSM, drives the buzzer (continuous or pulsed) with an
// operator mute, and mirrors the last sample plus a running peak to the display.
module dark_level_alarm #(
    parameter int                 DATA_W    = 16,
    parameter int                 DISP_W    = 32,
    parameter logic [DATA_W-1:0]  LOW_TH    = 16'h0600,
    parameter logic [DATA_W-1:0]  HIGH_TH   = 16'h4000,
    parameter logic [DATA_W-1:0]  HYST      = 16'h0040,
    parameter int                 DEB_CNT   = 3,
    parameter int                 BEEP_HALF = 2500000
) (
    input  logic              iCLK,
    input  logic              iRST,
    input  logic              iValid,
    input  logic [DATA_W-1:0] iValue,
    input  logic [1:0]        iMode,
    input  logic              iAck,
    output logic              oSound_on,
    output logic [1:0]        oAlarm_state,
    output logic [DISP_W-1:0] oDisplayDIG,
    output logic [DATA_W-1:0] oPeak
);

    typedef enum logic [1:0] {
        ST_NORMAL  = 2'd0,
        ST_PENDING = 2'd1,
        ST_ALARM   = 2'd2,
        ST_RECOVER = 2'd3
    } state_t;

    localparam int CNT_W  = $clog2(DEB_CNT + 1);
    localparam int BEEP_W = (BEEP_HALF > 1) ? $clog2(BEEP_HALF) : 1;
    // cnt value that, once incremented, reaches DEB_CNT
    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(DEB_CNT - 1);
    localparam logic [BEEP_W-1:0] BEEP_LAST = BEEP_W'(BEEP_HALF - 1);
    // recovery window bounds, one bit wider so LOW_TH+HYST cannot wrap
    localparam logic [DATA_W:0]   OK_LO = {1'b0, LOW_TH} + {1'b0, HYST};
    localparam logic [DATA_W:0]   OK_HI = {1'b0, HIGH_TH} - {1'b0, HYST};

    state_t              state_reg, state_next;
    logic [CNT_W-1:0]    cnt_reg, cnt_next;
    logic                mute_reg, mute_next;
    logic [BEEP_W-1:0]   beep_cnt_reg, beep_cnt_next;
    logic                phase_reg, phase_next;
    logic                sound_reg, sound_next;
    logic [DISP_W-1:0]   disp_reg;
    logic [DATA_W-1:0]   peak_reg;
    logic                enter_alarm;
    logic                armed_cur, armed_next;
    logic                is_out, is_ok;
    logic [DATA_W:0]     value_ext;

    assign value_ext = {1'b0, iValue};
    assign is_out    = (iValue < LOW_TH) || (iValue > HIGH_TH);
    assign is_ok     = (value_ext >= OK_LO) && (value_ext <= OK_HI);

    // Debounce FSM next state; only advances on valid strobes
    always_comb begin
        state_next  = state_reg;
        cnt_next    = cnt_reg;
        enter_alarm = 1'b0;
        if (iValid) begin
            case (state_reg)
                ST_NORMAL: begin
                    if (is_out) begin
                        if (DEB_CNT == 1) begin
                            state_next  = ST_ALARM;
                            enter_alarm = 1'b1;
                        end else begin
                            state_next = ST_PENDING;
                            cnt_next   = CNT_W'(1);
                        end
                    end
                end
                ST_PENDING: begin
                    if (is_out) begin
                        if (cnt_reg == CNT_LAST) begin
                            state_next  = ST_ALARM;
                            cnt_next    = '0;
                            enter_alarm = 1'b1;
                        end else begin
                            cnt_next = cnt_reg + 1'b1;
                        end
                    end else begin
                        state_next = ST_NORMAL;
                        cnt_next   = '0;
                    end
                end
                ST_ALARM: begin
                    if (is_ok) begin
                        if (DEB_CNT == 1) begin
                            state_next = ST_NORMAL;
                            cnt_next   = '0;
                        end else begin
                            state_next = ST_RECOVER;
                            cnt_next   = CNT_W'(1);
                        end
                    end else begin
                        cnt_next = '0;
                    end
                end
                default: begin
                    if (is_ok) begin
                        if (cnt_reg == CNT_LAST) begin
                            state_next = ST_NORMAL;
                            cnt_next   = '0;
                        end else begin
                            cnt_next = cnt_reg + 1'b1;
                        end
                    end else begin
                        state_next = ST_ALARM;
                        cnt_next   = '0;
                    end
                end
            endcase
        end
    end

    // Mute, beep phase and buzzer enable derived from the upcoming state
    always_comb begin
        mute_next = mute_reg;
        if (iAck && (state_reg == ST_ALARM || state_reg == ST_RECOVER))
            mute_next = 1'b1;
        // a fresh alarm or a return to NORMAL always re-arms the buzzer
        if (enter_alarm || state_next == ST_NORMAL)
            mute_next = 1'b0;

        armed_cur  = (state_reg == ST_ALARM || state_reg == ST_RECOVER) && !mute_reg;
        armed_next = (state_next == ST_ALARM || state_next == ST_RECOVER) && !mute_next;

        beep_cnt_next = beep_cnt_reg;
        phase_next    = phase_reg;
        if (enter_alarm) begin
            beep_cnt_next = '0;
            phase_next    = 1'b1;
        end else if (armed_cur) begin
            if (beep_cnt_reg == BEEP_LAST) begin
                beep_cnt_next = '0;
                phase_next    = ~phase_reg;
            end else begin
                beep_cnt_next = beep_cnt_reg + 1'b1;
            end
        end

        case (iMode)
            2'd0:    sound_next = 1'b0;
            2'd2:    sound_next = armed_next && phase_next;
            default: sound_next = armed_next;
        endcase
    end

    // Control state registers with asynchronous active-low reset
    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            state_reg    <= ST_NORMAL;
            cnt_reg      <= '0;
            mute_reg     <= 1'b0;
            beep_cnt_reg <= '0;
            phase_reg    <= 1'b0;
            sound_reg    <= 1'b0;
        end else begin
            state_reg    <= state_next;
            cnt_reg      <= cnt_next;
            mute_reg     <= mute_next;
            beep_cnt_reg <= beep_cnt_next;
            phase_reg    <= phase_next;
            sound_reg    <= sound_next;
        end
    end

    // Display mirror and running peak; iAck restarts the peak
    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            disp_reg <= '0;
            peak_reg <= '0;
        end else begin
            if (iValid)
                disp_reg <= DISP_W'(iValue);
            if (iAck)
                peak_reg <= iValid ? iValue : '0;
            else if (iValid && iValue > peak_reg)
                peak_reg <= iValue;
        end
    end

    assign oSound_on    = sound_reg;
    assign oAlarm_state = state_reg;
    assign oDisplayDIG  = disp_reg;
    assign oPeak        = peak_reg;

endmodule

// File: tb/tb_dark_level_alarm.sv
// Directed testbench for dark_level_alarm (DEB_CNT=3, BEEP_HALF=4).
// Each vector is {mode[1:0], ack, valid, value[15:0], exp_state[1:0], exp_sound}.
module tb_dark_level_alarm;

    logic        clk = 1'b0;
    logic        clk_en = 1'b1;
    logic        rst_n;
    logic        valid;
    logic [15:0] value;
    logic [1:0]  mode;
    logic        ack;
    logic        sound_on;
    logic [1:0]  alarm_state;
    logic [31:0] display_dig;
    logic [15:0] peak;

    int checks = 0;
    int fails  = 0;

    dark_level_alarm #(
        .DATA_W(16), .DISP_W(32), .LOW_TH(16'h0600), .HIGH_TH(16'h4000),
        .HYST(16'h0040), .DEB_CNT(3), .BEEP_HALF(4)
    ) dut (
        .iCLK(clk), .iRST(rst_n), .iValid(valid), .iValue(value), .iMode(mode),
        .iAck(ack), .oSound_on(sound_on), .oAlarm_state(alarm_state),
        .oDisplayDIG(display_dig), .oPeak(peak)
    );

    initial forever begin
        #5;
        if (clk_en) clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // drive one vector for one clock, sample 1ns after the edge
    task automatic apply(input logic [22:0] e);
        mode  = e[22:21];
        ack   = e[20];
        valid = e[19];
        value = e[18:3];
        @(posedge clk);
        #1;
        valid = 1'b0;
        ack   = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0; valid = 1'b0; value = '0; mode = 2'd1; ack = 1'b0;
        #12;
        checks++; if (alarm_state !== 2'd0) begin fails++; $display("FAIL reset_state: got %0d want 0", alarm_state); end
        checks++; if (sound_on !== 1'b0) begin fails++; $display("FAIL reset_sound: got %0b want 0", sound_on); end
        checks++; if (display_dig !== 32'h0) begin fails++; $display("FAIL reset_display: got %h want 0", display_dig); end
        checks++; if (peak !== 16'h0) begin fails++; $display("FAIL reset_peak: got %h want 0", peak); end
        rst_n = 1'b1;
        #5;
    endtask

    task automatic test_enter_alarm;
        logic [22:0] tbl [3] = '{
            {2'd1, 1'b0, 1'b1, 16'h0500, 2'd1, 1'b0},
            {2'd1, 1'b0, 1'b1, 16'h0500, 2'd1, 1'b0},
            {2'd1, 1'b0, 1'b1, 16'h0500, 2'd2, 1'b1}
        };
        for (int i = 0; i < 3; i++) begin
            apply(tbl[i]);
            checks++; if (alarm_state !== tbl[i][2:1]) begin fails++; $display("FAIL enter_state step %0d: got %0d want %0d", i, alarm_state, tbl[i][2:1]); end
            checks++; if (sound_on !== tbl[i][0]) begin fails++; $display("FAIL enter_sound step %0d: got %0b want %0b", i, sound_on, tbl[i][0]); end
        end
        checks++; if (display_dig !== 32'h0000_0500) begin fails++; $display("FAIL enter_display: got %h want 00000500", display_dig); end
    endtask

    task automatic test_recover;
        logic [22:0] tbl [12] = '{
            {2'd1, 1'b0, 1'b1, 16'h0620, 2'd2, 1'b1},
            {2'd1, 1'b0, 1'b1, 16'h1000, 2'd3, 1'b1},
            {2'd1, 1'b0, 1'b1, 16'h1000, 2'd3, 1'b1},
            {2'd1, 1'b0, 1'b1, 16'h1000, 2'd0, 1'b0},
            {2'd1, 1'b0, 1'b1, 16'h0500, 2'd1, 1'b0},
            {2'd1, 1'b0, 1'b1, 16'h0500, 2'd1, 1'b0},
            {2'd1, 1'b0, 1'b1, 16'h0500, 2'd2, 1'b1},
            {2'd1, 1'b0, 1'b1, 16'h1000, 2'd3, 1'b1},
            {2'd1, 1'b0, 1'b1, 16'h4100, 2'd2, 1'b1},
            {2'd1, 1'b0, 1'b1, 16'h1000, 2'd3, 1'b1},
            {2'd1, 1'b0, 1'b1, 16'h1000, 2'd3, 1'b1},
            {2'd1, 1'b0, 1'b1, 16'h1000, 2'd0, 1'b0}
        };
        for (int i = 0; i < 12; i++) begin
            apply(tbl[i]);
            checks++; if (alarm_state !== tbl[i][2:1]) begin fails++; $display("FAIL recover_state step %0d: got %0d want %0d", i, alarm_state, tbl[i][2:1]); end
            checks++; if (sound_on !== tbl[i][0]) begin fails++; $display("FAIL recover_sound step %0d: got %0b want %0b", i, sound_on, tbl[i][0]); end
        end
    endtask

    task automatic test_pending_abort;
        logic [22:0] tbl [11] = '{
            {2'd1, 1'b0, 1'b1, 16'h0500, 2'd1, 1'b0},
            {2'd1, 1'b0, 1'b0, 16'h0500, 2'd1, 1'b0},
            {2'd1, 1'b0, 1'b0, 16'h0500, 2'd1, 1'b0},
            {2'd1, 1'b0, 1'b1, 16'h0500, 2'd1, 1'b0},
            {2'd1, 1'b0, 1'b1, 16'h1000, 2'd0, 1'b0},
            {2'd1, 1'b0, 1'b1, 16'h0500, 2'd1, 1'b0},
            {2'd1, 1'b0, 1'b1, 16'h0500, 2'd1, 1'b0},
            {2'd1, 1'b0, 1'b1, 16'h0500, 2'd2, 1'b1},
            {2'd1, 1'b0, 1'b1, 16'h1000, 2'd3, 1'b1},
            {2'd1, 1'b0, 1'b1, 16'h1000, 2'd3, 1'b1},
            {2'd1, 1'b0, 1'b1, 16'h1000, 2'd0, 1'b0}
        };
        for (int i = 0; i < 11; i++) begin
            apply(tbl[i]);
            checks++; if (alarm_state !== tbl[i][2:1]) begin fails++; $display("FAIL abort_state step %0d: got %0d want %0d", i, alarm_state, tbl[i][2:1]); end
            checks++; if (sound_on !== tbl[i][0]) begin fails++; $display("FAIL abort_sound step %0d: got %0b want %0b", i, sound_on, tbl[i][0]); end
        end
    endtask

    task automatic test_thresholds;
        logic [22:0] tbl [12] = '{
            {2'd1, 1'b0, 1'b1, 16'h0600, 2'd0, 1'b0},
            {2'd1, 1'b0, 1'b1, 16'h4000, 2'd0, 1'b0},
            {2'd1, 1'b0, 1'b1, 16'h4001, 2'd1, 1'b0},
            {2'd1, 1'b0, 1'b1, 16'h05FF, 2'd1, 1'b0},
            {2'd1, 1'b0, 1'b1, 16'h0600, 2'd0, 1'b0},
            {2'd1, 1'b0, 1'b1, 16'h05FF, 2'd1, 1'b0},
            {2'd1, 1'b0, 1'b1, 16'h05FF, 2'd1, 1'b0},
            {2'd1, 1'b0, 1'b1, 16'h4001, 2'd2, 1'b1},
            {2'd1, 1'b0, 1'b1, 16'h063F, 2'd2, 1'b1},
            {2'd1, 1'b0, 1'b1, 16'h0640, 2'd3, 1'b1},
            {2'd1, 1'b0, 1'b1, 16'h3FC1, 2'd2, 1'b1},
            {2'd1, 1'b0, 1'b1, 16'h3FC0, 2'd3, 1'b1}
        };
        logic [22:0] tail [2] = '{
            {2'd1, 1'b0, 1'b1, 16'h1000, 2'd3, 1'b1},
            {2'd1, 1'b0, 1'b1, 16'h1000, 2'd0, 1'b0}
        };
        for (int i = 0; i < 12; i++) begin
            apply(tbl[i]);
            checks++; if (alarm_state !== tbl[i][2:1]) begin fails++; $display("FAIL thresh_state step %0d: got %0d want %0d", i, alarm_state, tbl[i][2:1]); end
            checks++; if (sound_on !== tbl[i][0]) begin fails++; $display("FAIL thresh_sound step %0d: got %0b want %0b", i, sound_on, tbl[i][0]); end
        end
        for (int i = 0; i < 2; i++) begin
            apply(tail[i]);
            checks++; if (alarm_state !== tail[i][2:1]) begin fails++; $display("FAIL thresh_tail_state step %0d: got %0d want %0d", i, alarm_state, tail[i][2:1]); end
        end
    endtask

    task automatic test_beep;
        logic [22:0] tbl [31] = '{
            {2'd2, 1'b0, 1'b1, 16'h0500, 2'd1, 1'b0},
            {2'd2, 1'b0, 1'b1, 16'h0500, 2'd1, 1'b0},
            {2'd2, 1'b0, 1'b1, 16'h0500, 2'd2, 1'b1},
            {2'd2, 1'b0, 1'b0, 16'h0000, 2'd2, 1'b1},
            {2'd2, 1'b0, 1'b0, 16'h0000, 2'd2, 1'b1},
            {2'd2, 1'b0, 1'b0, 16'h0000, 2'd2, 1'b1},
            {2'd2, 1'b0, 1'b0, 16'h0000, 2'd2, 1'b0},
            {2'd2, 1'b0, 1'b0, 16'h0000, 2'd2, 1'b0},
            {2'd2, 1'b0, 1'b0, 16'h0000, 2'd2, 1'b0},
            {2'd2, 1'b0, 1'b0, 16'h0000, 2'd2, 1'b0},
            {2'd2, 1'b0, 1'b0, 16'h0000, 2'd2, 1'b1},
            {2'd2, 1'b0, 1'b0, 16'h0000, 2'd2, 1'b1},
            {2'd2, 1'b0, 1'b0, 16'h0000, 2'd2, 1'b1},
            {2'd2, 1'b0, 1'b0, 16'h0000, 2'd2, 1'b1},
            {2'd2, 1'b1, 1'b0, 16'h0000, 2'd2, 1'b0},
            {2'd2, 1'b0, 1'b0, 16'h0000, 2'd2, 1'b0},
            {2'd2, 1'b0, 1'b0, 16'h0000, 2'd2, 1'b0},
            {2'd1, 1'b0, 1'b0, 16'h0000, 2'd2, 1'b0},
            {2'd2, 1'b0, 1'b1, 16'h1000, 2'd3, 1'b0},
            {2'd2, 1'b0, 1'b1, 16'h1000, 2'd3, 1'b0},
            {2'd2, 1'b0, 1'b1, 16'h1000, 2'd0, 1'b0},
            {2'd2, 1'b0, 1'b1, 16'h0500, 2'd1, 1'b0},
            {2'd2, 1'b0, 1'b1, 16'h0500, 2'd1, 1'b0},
            {2'd2, 1'b0, 1'b1, 16'h0500, 2'd2, 1'b1},
            {2'd2, 1'b0, 1'b0, 16'h0000, 2'd2, 1'b1},
            {2'd0, 1'b0, 1'b0, 16'h0000, 2'd2, 1'b0},
            {2'd3, 1'b0, 1'b0, 16'h0000, 2'd2, 1'b1},
            {2'd2, 1'b0, 1'b0, 16'h0000, 2'd2, 1'b0},
            {2'd1, 1'b0, 1'b1, 16'h1000, 2'd3, 1'b1},
            {2'd1, 1'b0, 1'b1, 16'h1000, 2'd3, 1'b1},
            {2'd1, 1'b0, 1'b1, 16'h1000, 2'd0, 1'b0}
        };
        for (int i = 0; i < 31; i++) begin
            apply(tbl[i]);
            checks++; if (alarm_state !== tbl[i][2:1]) begin fails++; $display("FAIL beep_state step %0d: got %0d want %0d", i, alarm_state, tbl[i][2:1]); end
            checks++; if (sound_on !== tbl[i][0]) begin fails++; $display("FAIL beep_sound step %0d: got %0b want %0b", i, sound_on, tbl[i][0]); end
        end
    endtask

    task automatic test_ack;
        logic [22:0] tbl [13] = '{
            {2'd1, 1'b0, 1'b1, 16'h0500, 2'd1, 1'b0},
            {2'd1, 1'b0, 1'b1, 16'h0500, 2'd1, 1'b0},
            {2'd1, 1'b0, 1'b1, 16'h0500, 2'd2, 1'b1},
            {2'd1, 1'b0, 1'b1, 16'h1000, 2'd3, 1'b1},
            {2'd1, 1'b1, 1'b0, 16'h0000, 2'd3, 1'b0},
            {2'd1, 1'b0, 1'b1, 16'h4100, 2'd2, 1'b0},
            {2'd1, 1'b0, 1'b1, 16'h1000, 2'd3, 1'b0},
            {2'd1, 1'b0, 1'b1, 16'h1000, 2'd3, 1'b0},
            {2'd1, 1'b0, 1'b1, 16'h1000, 2'd0, 1'b0},
            {2'd1, 1'b0, 1'b1, 16'h0500, 2'd1, 1'b0},
            {2'd1, 1'b0, 1'b1, 16'h0500, 2'd1, 1'b0},
            {2'd1, 1'b1, 1'b1, 16'h0500, 2'd2, 1'b1},
            {2'd1, 1'b1, 1'b0, 16'h0000, 2'd2, 1'b0}
        };
        logic [22:0] tail [3] = '{
            {2'd1, 1'b0, 1'b1, 16'h1000, 2'd3, 1'b0},
            {2'd1, 1'b0, 1'b1, 16'h1000, 2'd3, 1'b0},
            {2'd1, 1'b0, 1'b1, 16'h1000, 2'd0, 1'b0}
        };
        for (int i = 0; i < 13; i++) begin
            apply(tbl[i]);
            checks++; if (alarm_state !== tbl[i][2:1]) begin fails++; $display("FAIL ack_state step %0d: got %0d want %0d", i, alarm_state, tbl[i][2:1]); end
            checks++; if (sound_on !== tbl[i][0]) begin fails++; $display("FAIL ack_sound step %0d: got %0b want %0b", i, sound_on, tbl[i][0]); end
        end
        for (int i = 0; i < 3; i++) apply(tail[i]);
        checks++; if (alarm_state !== 2'd0) begin fails++; $display("FAIL ack_tail_state: got %0d want 0", alarm_state); end
    endtask

    task automatic test_peak;
        logic [22:0] tbl [6] = '{
            {2'd1, 1'b1, 1'b0, 16'h0000, 2'd0, 1'b0},
            {2'd1, 1'b0, 1'b1, 16'h0200, 2'd0, 1'b0},
            {2'd1, 1'b0, 1'b1, 16'h3000, 2'd0, 1'b0},
            {2'd1, 1'b0, 1'b1, 16'h1000, 2'd0, 1'b0},
            {2'd1, 1'b0, 1'b0, 16'h7777, 2'd0, 1'b0},
            {2'd1, 1'b1, 1'b1, 16'h0100, 2'd0, 1'b0}
        };
        logic [15:0] exp_peak [6] = '{16'h0000, 16'h0200, 16'h3000, 16'h3000, 16'h3000, 16'h0100};
        logic [31:0] exp_disp [6] = '{32'h1000, 32'h0200, 32'h3000, 32'h1000, 32'h1000, 32'h0100};
        for (int i = 0; i < 6; i++) begin
            apply(tbl[i]);
            checks++; if (peak !== exp_peak[i]) begin fails++; $display("FAIL peak step %0d: got %h want %h", i, peak, exp_peak[i]); end
            checks++; if (display_dig !== exp_disp[i]) begin fails++; $display("FAIL display step %0d: got %h want %h", i, display_dig, exp_disp[i]); end
        end
    endtask

    task automatic test_async_reset;
        apply({2'd2, 1'b0, 1'b1, 16'h1000, 2'd0, 1'b0});
        apply({2'd2, 1'b0, 1'b1, 16'h0500, 2'd0, 1'b0});
        apply({2'd2, 1'b0, 1'b1, 16'h0500, 2'd0, 1'b0});
        apply({2'd2, 1'b0, 1'b1, 16'h0500, 2'd0, 1'b0});
        checks++; if (sound_on !== 1'b1) begin fails++; $display("FAIL arst_pre_sound: got %0b want 1", sound_on); end
        clk_en = 1'b0;
        #3;
        rst_n = 1'b0;
        #1;
        checks++; if (sound_on !== 1'b0) begin fails++; $display("FAIL arst_sound: got %0b want 0", sound_on); end
        checks++; if (alarm_state !== 2'd0) begin fails++; $display("FAIL arst_state: got %0d want 0", alarm_state); end
        checks++; if (display_dig !== 32'h0) begin fails++; $display("FAIL arst_display: got %h want 0", display_dig); end
        checks++; if (peak !== 16'h0) begin fails++; $display("FAIL arst_peak: got %h want 0", peak); end
        #10;
        rst_n = 1'b1;
        #3;
        clk_en = 1'b1;
        apply({2'd2, 1'b0, 1'b0, 16'h0000, 2'd0, 1'b0});
        checks++; if (alarm_state !== 2'd0) begin fails++; $display("FAIL arst_post_state: got %0d want 0", alarm_state); end
        checks++; if (sound_on !== 1'b0) begin fails++; $display("FAIL arst_post_sound: got %0b want 0", sound_on); end
    endtask

    initial begin
        test_reset();
        test_enter_alarm();
        test_recover();
        test_pending_abort();
        test_thresholds();
        test_beep();
        test_ack();
        test_peak();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
